// File: rtl/band_playback_scheduler.sv
// Shares one sample ROM read port across NUM_BANDS band channels. On each frame
// strobe it issues one read per band in ascending order, advances and wraps each
// band's playback offset, and emits one tagged sample per band after the ROM latency.
module band_playback_scheduler #(
  parameter int unsigned NUM_BANDS  = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BAND_W     = $clog2(NUM_BANDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_BANDS-1:0]  band_en,
  input  logic                  cfg_we,
  input  logic [BAND_W-1:0]     cfg_band,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic [BAND_W-1:0]     sample_band,
  output logic                  sample_valid,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  localparam logic [BAND_W-1:0]     LastBand  = BAND_W'(NUM_BANDS - 1);
  localparam logic [1:0]            DrainLast = 2'(RD_LATENCY);
  localparam int unsigned           LastTag   = RD_LATENCY - 1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne   = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [BAND_W-1:0]     band_q, band_d;
  logic [1:0]            drain_q, drain_d;

  logic [ADDR_WIDTH-1:0] base_q [NUM_BANDS];
  logic [ADDR_WIDTH-1:0] len_q  [NUM_BANDS];
  logic [ADDR_WIDTH-1:0] off_q  [NUM_BANDS];

  logic                  issue_act;
  logic [ADDR_WIDTH-1:0] off_next;
  logic                  cfg_ok;

  // Tag pipe travels alongside the ROM read so the data and its band line up.
  logic                  tag_valid_q [RD_LATENCY];
  logic [BAND_W-1:0]     tag_band_q  [RD_LATENCY];
  logic                  tag_zero_q  [RD_LATENCY];

  logic                  sample_valid_q;
  logic                  frame_done_q;
  logic [DATA_WIDTH-1:0] sample_out_q;
  logic [BAND_W-1:0]     sample_band_q;
  logic                  overrun_q;

  // Out-of-range band numbers can only occur when NUM_BANDS is not a power of two.
  if (NUM_BANDS == (2 ** BAND_W)) begin : gen_cfg_all
    assign cfg_ok = 1'b1;
  end else begin : gen_cfg_chk
    assign cfg_ok = (32'(cfg_band) < NUM_BANDS);
  end

  assign busy = (state_q != StIdle);

  // ROM request for the band in its issue slot, plus its wrapped next offset.
  always_comb begin
    issue_act = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = '0;
    off_next  = '0;
    if (state_q == StIssue) begin
      issue_act = band_en[band_q] && (len_q[band_q] != '0);
      off_next  = (off_q[band_q] == (len_q[band_q] - AddrOne)) ? '0 : off_q[band_q] + AddrOne;
      if (issue_act) begin
        rom_en   = 1'b1;
        rom_addr = base_q[band_q] + off_q[band_q];
      end
    end
  end

  // Next-state logic: walk the bands, then drain the read pipe before going idle.
  always_comb begin
    state_d = state_q;
    band_d  = band_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StIssue;
          band_d  = '0;
        end
      end
      StIssue: begin
        if (band_q == LastBand) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          band_d = band_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StIdle;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      band_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
      drain_q <= drain_d;
    end
  end

  // Per-band configuration and playback offsets; a config write overrides the
  // offset advance of a read issued to the same band in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        off_q[i]  <= '0;
      end
    end else begin
      if (issue_act) begin
        off_q[band_q] <= off_next;
      end
      if (cfg_we && cfg_ok) begin
        base_q[cfg_band] <= cfg_base;
        len_q[cfg_band]  <= cfg_len;
        off_q[cfg_band]  <= '0;
      end
    end
  end

  // Tag pipe shift register, RD_LATENCY stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_valid_q[i] <= 1'b0;
        tag_band_q[i]  <= '0;
        tag_zero_q[i]  <= 1'b0;
      end
    end else begin
      tag_valid_q[0] <= (state_q == StIssue);
      tag_band_q[0]  <= band_q;
      tag_zero_q[0]  <= !issue_act;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_band_q[i]  <= tag_band_q[i-1];
        tag_zero_q[i]  <= tag_zero_q[i-1];
      end
    end
  end

  // Sample output register; data and tag hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      sample_out_q   <= '0;
      sample_band_q  <= '0;
    end else begin
      sample_valid_q <= tag_valid_q[LastTag];
      frame_done_q   <= tag_valid_q[LastTag] && (tag_band_q[LastTag] == LastBand);
      if (tag_valid_q[LastTag]) begin
        sample_out_q  <= tag_zero_q[LastTag] ? '0 : rom_dout;
        sample_band_q <= tag_band_q[LastTag];
      end
    end
  end

  // Sticky flag for frame strobes that arrive mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (enable && busy) begin
      overrun_q <= 1'b1;
    end
  end

  assign sample_valid = sample_valid_q;
  assign frame_done   = frame_done_q;
  assign sample_out   = sample_out_q;
  assign sample_band  = sample_band_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_band_playback_scheduler.sv
// Bench for band_playback_scheduler: directed frames then randomized frames,
// checked cycle by cycle against a per-band table model.
module tb_band_playback_scheduler;

  localparam int N  = 16;
  localparam int L  = 1;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  band_en = '0;
  logic          cfg_we = 1'b0;
  logic [BW-1:0] cfg_band = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic [DW-1:0] sample_out;
  logic [BW-1:0] sample_band;
  logic          sample_valid;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  int total = 0;
  int bad = 0;

  // Reference model: per-band tables and the sample expected from each slot.
  logic [AW-1:0] m_base [N];
  logic [AW-1:0] m_len  [N];
  logic [AW-1:0] m_off  [N];
  logic [DW-1:0] exp_val[N];
  logic          exp_ovr;

  band_playback_scheduler #(
    .NUM_BANDS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .BAND_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .band_en(band_en),
    .cfg_we(cfg_we), .cfg_band(cfg_band), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .sample_out(sample_out), .sample_band(sample_band), .sample_valid(sample_valid),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM returns data = address one cycle after a read; garbage when not read.
  logic          rom_en_d = 1'b0;
  logic [AW-1:0] rom_addr_d = '0;
  always @(posedge clk) begin
    rom_en_d   <= rom_en;
    rom_addr_d <= rom_addr;
  end
  assign rom_dout = rom_en_d ? rom_addr_d : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_base[i] = '0;
      m_len[i]  = '0;
      m_off[i]  = '0;
    end
    exp_ovr = 1'b0;
  endtask

  task automatic model_cfg(input logic [BW-1:0] b, input logic [AW-1:0] base,
                           input logic [AW-1:0] len);
    m_base[b] = base;
    m_len[b]  = len;
    m_off[b]  = '0;
  endtask

  // Configuration write while idle.
  task automatic cfg_write(input logic [BW-1:0] b, input logic [AW-1:0] base,
                           input logic [AW-1:0] len);
    cfg_we = 1'b1;
    cfg_band = b;
    cfg_base = base;
    cfg_len = len;
    tick();
    cfg_we = 1'b0;
    model_cfg(b, base, len);
  endtask

  // One frame: enable at cycle t, then check every cycle t+1..t+N+L+3.
  // cfg_c / en2_c give the cycle offset of a mid-frame write / strobe (-1 = none).
  task automatic run_frame(input logic [N-1:0] en, input int cfg_c, input logic [BW-1:0] cb,
                           input logic [AW-1:0] cbase, input logic [AW-1:0] clen,
                           input int en2_c);
    int k;
    int k2;
    logic act;
    logic [AW-1:0] ea;
    band_en = en;
    enable = 1'b1;
    @(negedge clk);
    chk("busy_before", busy, 0);
    tick();
    enable = 1'b0;
    for (int c = 1; c <= N + L + 3; c++) begin
      if (c == en2_c) enable = 1'b1;
      if (c == cfg_c) begin
        cfg_we = 1'b1;
        cfg_band = cb;
        cfg_base = cbase;
        cfg_len = clen;
      end
      @(negedge clk);
      chk("busy", busy, 32'(c <= N + L + 1));
      chk("overrun", overrun, exp_ovr);
      k = c - 1;
      if (k < N) begin
        act = en[k] && (m_len[k] != '0);
        ea = m_base[k] + m_off[k];
        chk("rom_en", rom_en, act);
        if (act) begin
          chk("rom_addr", rom_addr, ea);
          m_off[k] = (32'(m_off[k]) == 32'(m_len[k]) - 1) ? '0 : m_off[k] + 16'd1;
        end
        exp_val[k] = act ? ea : '0;
      end else begin
        chk("rom_en_drain", rom_en, 0);
      end
      k2 = c - L - 2;
      if (k2 >= 0 && k2 < N) begin
        chk("sample_valid", sample_valid, 1);
        chk("sample_band", sample_band, k2);
        chk("sample_out", sample_out, exp_val[k2]);
      end else begin
        chk("sample_valid_idle", sample_valid, 0);
      end
      chk("frame_done", frame_done, 32'(c == N + L + 1));
      if (c == cfg_c) model_cfg(cb, cbase, clen);
      if (enable && c <= N + L + 1) exp_ovr = 1'b1;
      tick();
      enable = 1'b0;
      cfg_we = 1'b0;
    end
  endtask

  // Frame interrupted by reset at t+8; nothing may emerge afterwards.
  task automatic run_reset_frame();
    band_en = '1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_band", sample_band, 0);
    model_clear();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_valid", sample_valid, 0);
      chk("post_rst_done", frame_done, 0);
      chk("post_rst_busy", busy, 0);
      tick();
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_rom_en", rom_en, 0);
    chk("reset_sample_valid", sample_valid, 0);
    chk("reset_sample_out", sample_out, 0);
    chk("reset_sample_band", sample_band, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    tick();
    rst = 1'b0;
    tick();

    // No configuration: every band silent.
    run_frame('1, -1, '0, '0, '0, -1);

    // Band 3 table of 4 samples at 0x0100, wraps on the fifth frame.
    cfg_write(4'd3, 16'h0100, 16'd4);
    for (int f = 0; f < 5; f++) run_frame('1, -1, '0, '0, '0, -1);

    // Bands 0 and 15; only band 15 enabled, its address wraps past 0xFFFF.
    cfg_write(4'd0, 16'h0000, 16'd3);
    cfg_write(4'd15, 16'hFFFE, 16'd3);
    for (int f = 0; f < 3; f++) run_frame(16'h8000, -1, '0, '0, '0, -1);

    // Second strobe mid-frame sets sticky overrun; the following frame is normal.
    run_frame('1, -1, '0, '0, '0, 5);
    run_frame('1, -1, '0, '0, '0, -1);

    // Config write to band 3 during its own issue slot.
    cfg_write(4'd3, 16'h0100, 16'd4);
    run_frame('1, -1, '0, '0, '0, -1);
    run_frame('1, -1, '0, '0, '0, -1);
    run_frame('1, 4, 4'd3, 16'h0200, 16'd2, -1);
    run_frame('1, -1, '0, '0, '0, -1);

    // Reset in the middle of a frame clears everything.
    run_reset_frame();
    run_frame('1, -1, '0, '0, '0, -1);

    // Randomized frames with idle and mid-frame reconfiguration.
    for (int f = 0; f < 30; f++) begin
      int nw;
      int cc;
      int e2;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        cfg_write(4'($urandom_range(0, N - 1)), 16'($urandom), 16'($urandom_range(0, 6)));
      end
      cc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, N + L + 2) : -1;
      e2 = ($urandom_range(0, 3) == 0) ? $urandom_range(2, N) : -1;
      run_frame(16'($urandom), cc, 4'($urandom_range(0, N - 1)), 16'($urandom),
                16'($urandom_range(0, 6)), e2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
